// File: rtl/spr_dma_ctrl.sv
// OAM DMA sequencer: a CPU write to TRIG_ADDR halts the CPU and copies one page into sprite RAM.
// Optional build macro SPR_DMA_ODD_ALIGN_EN adds an extra halt cycle when triggered on an odd CPU cycle.
module spr_dma_ctrl #(
  parameter logic [15:0] TRIG_ADDR     = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        cyc_en_in,
  input  logic [15:0] cpu_a_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  input  logic [7:0]  bus_d_in,
  output logic        cpu_rdy_out,
  output logic        active_out,
  output logic [15:0] a_out,
  output logic [7:0]  d_out,
  output logic        r_nw_out,
  output logic [7:0]  cnt_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HALT  = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t     state;
  logic [7:0] page;
  logic       trigger;
  logic       halt_done;

  // Only the CPU's own bus is watched, so the DMA's OAM writes can never retrigger it.
  assign trigger = cyc_en_in & ~cpu_r_nw_in & (cpu_a_in == TRIG_ADDR);

`ifdef SPR_DMA_ODD_ALIGN_EN
  logic parity;
  logic halt_extra;
  assign halt_done = ~halt_extra;
`else
  assign halt_done = 1'b1;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      page        <= 8'h00;
      cnt_out     <= 8'h00;
      cpu_rdy_out <= 1'b1;
      active_out  <= 1'b0;
      a_out       <= 16'h0000;
      d_out       <= 8'h00;
      r_nw_out    <= 1'b1;
`ifdef SPR_DMA_ODD_ALIGN_EN
      parity      <= 1'b0;
      halt_extra  <= 1'b0;
`endif
    end else if (cyc_en_in) begin
`ifdef SPR_DMA_ODD_ALIGN_EN
      parity <= ~parity;
`endif
      case (state)
        IDLE: begin
          if (trigger) begin
            page        <= cpu_d_in;
            cnt_out     <= 8'h00;
            cpu_rdy_out <= 1'b0;
            state       <= HALT;
`ifdef SPR_DMA_ODD_ALIGN_EN
            halt_extra  <= parity;
`endif
          end
        end
        HALT: begin
`ifdef SPR_DMA_ODD_ALIGN_EN
          halt_extra <= 1'b0;
`endif
          if (halt_done) begin
            state      <= READ;
            active_out <= 1'b1;
            a_out      <= {page, cnt_out};
            r_nw_out   <= 1'b1;
            d_out      <= 8'h00;
          end
        end
        READ: begin
          // d_out doubles as the latch for the byte just read.
          state    <= WRITE;
          a_out    <= OAM_DATA_ADDR;
          r_nw_out <= 1'b0;
          d_out    <= bus_d_in;
        end
        WRITE: begin
          if (cnt_out == LAST_IDX) begin
            state       <= IDLE;
            active_out  <= 1'b0;
            cpu_rdy_out <= 1'b1;
            a_out       <= 16'h0000;
            d_out       <= 8'h00;
            r_nw_out    <= 1'b1;
          end else begin
            // Low byte wraps inside the page; the page byte is never incremented.
            cnt_out  <= cnt_out + 8'd1;
            state    <= READ;
            a_out    <= {page, cnt_out + 8'd1};
            r_nw_out <= 1'b1;
            d_out    <= 8'h00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
